pixel_write_queue: RTL



---
 rtl/pixel_write_queue_pkg.sv | 12 +
 rtl/pixel_write_queue_fifo.sv | 50 +++++
 rtl/pixel_write_queue.sv | 85 ++++++++
 3 files changed

// File: rtl/pixel_write_queue_pkg.sv
// Shared frame-buffer geometry and pixel types for the pixel write queue.
// Defaults target a 640x480 frame buffer with 24-bit color.
package pixel_write_queue_pkg;

    localparam int unsigned FB_H_RES  = 640;
    localparam int unsigned FB_V_RES  = 480;
    localparam int unsigned FB_ADDR_W = 19;

    typedef logic [2:0][7:0] color;
    typedef logic [FB_ADDR_W-1:0] fb_addr;

endpackage

// File: rtl/pixel_write_queue_fifo.sv
// Generic synchronous FIFO with register-array storage and an occupancy counter.
// The caller guarantees no push when full and no pop when empty.
module pixel_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Head is read straight from the array so it is valid in the pop cycle
    assign dout = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_queue.sv
// Elastic queue from the ray-cast pixel producer to the frame-buffer write port,
// with linear address generation, frame-end pulse and sticky drop flag.
module pixel_write_queue
    import pixel_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned H_RES  = FB_H_RES,
    parameter int unsigned V_RES  = FB_V_RES,
    parameter int unsigned ADDR_W = FB_ADDR_W
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [9:0]             In_X,
    input  logic [9:0]             In_Y,
    input  logic [23:0]            In_Color,
    input  logic                   Fb_Grant,
    output logic                   Fb_Write,
    output logic [ADDR_W-1:0]      Fb_Addr,
    output logic [23:0]            Fb_Color,
    output logic                   Frame_Done,
    output logic                   Drop_Err,
    output logic [$clog2(DEPTH):0] Level
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + 24;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    logic              in_range;
    logic              hs;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] addr;
    logic [ENT_W-1:0]  din;
    logic [ENT_W-1:0]  dout;
    logic [ADDR_W-1:0] head_addr;
    color              head_color;

    assign In_Ready = (Level != LVL_W'(DEPTH));
    assign in_range = (32'(In_X) < H_RES) && (32'(In_Y) < V_RES);
    assign hs       = In_Valid && In_Ready;
    assign push     = hs && in_range;
    assign pop      = Fb_Grant && (Level != '0);

    assign addr = ADDR_W'(In_Y) * ADDR_W'(H_RES) + ADDR_W'(In_X);
    assign din  = {addr, In_Color};
    assign {head_addr, head_color} = dout;

    pixel_fifo #(
        .WIDTH(ENT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .Clk  (Clk),
        .Reset(Reset),
        .push (push),
        .pop  (pop),
        .din  (din),
        .dout (dout),
        .level(Level)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Fb_Write   <= 1'b0;
            Fb_Addr    <= '0;
            Fb_Color   <= '0;
            Frame_Done <= 1'b0;
            Drop_Err   <= 1'b0;
        end else begin
            Fb_Write   <= pop;
            Frame_Done <= pop && (head_addr == LAST_ADDR);
            if (pop) begin
                Fb_Addr  <= head_addr;
                Fb_Color <= head_color;
            end
            // Out-of-range pixels complete the handshake but never enter the queue
            if (hs && !in_range) begin
                Drop_Err <= 1'b1;
            end
        end
    end

endmodule
